// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - IF/MEM requester, memory-side and stall signals of the shared memory port
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // Instruction fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  // Load/store requester
  logic              dm_req;
  logic              dm_we;
  logic [BE_W-1:0]   dm_be;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  // Unified memory port
  logic              mem_req;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  // Pipeline control and status
  logic              stall_if;
  logic              stall_mem;
  logic              err;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output stall_if, stall_mem, err
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  stall_if, stall_mem, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-outstanding arbiter sharing one memory port between fetch and load/store
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 255,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;
  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);
  localparam logic [WC_W-1:0] WC_MAX  = WC_W'(TIMEOUT);
  localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_GNT  = 2'd1,
    S_WAIT_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_owner_dm;
  logic              r_we;
  logic [BE_W-1:0]   r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [WC_W-1:0]   r_wait;
  logic [SC_W-1:0]   r_starve;
  logic              r_err;

  logic w_pick_if;
  logic w_expired;
  logic w_start;
  logic w_gnt;
  logic w_resp;
  logic w_timeout;
  logic w_if_rvalid;
  logic w_dm_rvalid;

  // Load/store normally wins; a fetch starved STARVE_MAX times in a row gets one turn.
  assign w_pick_if = bus.if_req & (~bus.dm_req | (r_starve == SC_MAX));
  // The counter saturates, so a grant landing on the last allowed cycle still leaves
  // WAIT_RESP expired unless the response arrives in its first cycle.
  assign w_expired = (r_wait >= WC_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode; a grant or response beats a coincident timeout
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_gnt       = 1'b0;
    w_resp      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.if_req | bus.dm_req) begin
          w_start     = 1'b1;
          w_state_nxt = S_WAIT_GNT;
        end
      end
      S_WAIT_GNT: begin
        if (bus.mem_gnt) begin
          w_gnt       = 1'b1;
          w_state_nxt = S_WAIT_RESP;
        end else if (w_expired) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_RESP: begin
        if (bus.mem_rvalid) begin
          w_resp      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_expired) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Capture owner and request fields at arbitration; run the watchdog and starvation counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner_dm <= 1'b0;
      r_we       <= 1'b0;
      r_be       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wait     <= '0;
      r_starve   <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_start) begin
        r_owner_dm <= ~w_pick_if;
        r_wait     <= '0;
        if (w_pick_if) begin
          r_we     <= 1'b0;
          r_be     <= '1;
          r_addr   <= bus.if_addr;
          r_wdata  <= '0;
          r_starve <= '0;
        end else begin
          r_we    <= bus.dm_we;
          r_be    <= bus.dm_be;
          r_addr  <= bus.dm_addr;
          r_wdata <= bus.dm_wdata;
          if (bus.if_req && (r_starve != SC_MAX)) begin
            r_starve <= r_starve + 1'b1;
          end
        end
      end else if ((r_state != S_IDLE) && (r_wait != WC_MAX)) begin
        r_wait <= r_wait + 1'b1;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  // A timeout completes the owner's transaction with zero data so it never hangs
  assign w_if_rvalid = (w_resp | w_timeout) & ~r_owner_dm;
  assign w_dm_rvalid = (w_resp | w_timeout) &  r_owner_dm;

  assign bus.mem_req   = (r_state == S_WAIT_GNT);
  assign bus.mem_we    = r_we;
  assign bus.mem_be    = r_be;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;

  assign bus.if_gnt    = w_gnt & ~r_owner_dm;
  assign bus.dm_gnt    = w_gnt &  r_owner_dm;
  assign bus.if_rvalid = w_if_rvalid;
  assign bus.dm_rvalid = w_dm_rvalid;
  assign bus.if_rdata  = (w_resp & ~r_owner_dm) ? bus.mem_rdata : '0;
  assign bus.dm_rdata  = (w_resp &  r_owner_dm) ? bus.mem_rdata : '0;

  assign bus.stall_if  = bus.if_req & ~w_if_rvalid;
  assign bus.stall_mem = bus.dm_req & ~w_dm_rvalid;
  assign bus.err       = r_err;
endmodule
